// File: rtl/controle_linhas_bloq_pkg.sv
// Shared types and constants for the blocking-row controller.
// Imported by the controller top and by the optional hole generator.
package pacote_linhas_bloq;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SOBE   = 2'd1,
        DESCE  = 2'd2
    } estado_t;

    localparam logic [2:0] MAX_BLOQ     = 3'd7;
    localparam int         PASSO_BURACO = 3;

endpackage

// File: rtl/controle_linhas_bloq_if.sv
// Row-write handshake between the blocking-row controller (master)
// and the board memory writer (slave).
interface controle_linhas_bloq_if #(
    parameter int COLUNAS = 10,
    parameter int LINHA_W = 5
);

    logic               escreve;
    logic [LINHA_W-1:0] endereco_linha;
    logic [COLUNAS-1:0] dado_linha;
    logic               ack_escrita;

    modport master (
        output escreve,
        output endereco_linha,
        output dado_linha,
        input  ack_escrita
    );

    modport slave (
        input  escreve,
        input  endereco_linha,
        input  dado_linha,
        output ack_escrita
    );

endinterface

// File: rtl/controle_linhas_bloq_buraco.sv
// Hole-column counter for inserted blocking rows: advances by PASSO_BURACO
// modulo COLUNAS on each strobe. Only used when LINHAS_BLOQ_BURACO_EN is defined.
module gerador_buraco
    import pacote_linhas_bloq::*;
#(
    parameter int COLUNAS = 10,
    parameter int IDX_W   = $clog2(COLUNAS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             avanca_i,
    output logic [IDX_W-1:0] buraco_o
);

    logic [IDX_W-1:0] buraco_q;
    logic [IDX_W-1:0] buraco_d;
    logic [IDX_W:0]   soma;

    // One extra bit keeps buraco+PASSO from overflowing before the wrap compare.
    always_comb begin
        soma     = {1'b0, buraco_q} + (IDX_W+1)'(PASSO_BURACO);
        buraco_d = buraco_q;
        if (avanca_i) begin
            if (soma >= (IDX_W+1)'(COLUNAS)) begin
                buraco_d = IDX_W'(soma - (IDX_W+1)'(COLUNAS));
            end else begin
                buraco_d = IDX_W'(soma);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buraco_q <= '0;
        end else begin
            buraco_q <= buraco_d;
        end
    end

    assign buraco_o = buraco_q;

endmodule

// File: rtl/controle_linhas_bloq.sv
// Moves the blocking-row stack one row per write toward the score counter's level.
// Optional feature macro: LINHAS_BLOQ_BURACO_EN (one hole per inserted row).
//
//   state  | meaning
//   OCIOSO | no request; compare target with current level
//   SOBE   | writing a full row on top of the stack, waiting ack
//   DESCE  | clearing the topmost blocking row, waiting ack
module controle_linhas_bloq
    import pacote_linhas_bloq::*;
#(
    parameter int COLUNAS = 10,
    parameter int LINHAS  = 20,
    parameter int LINHA_W = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   linhas_bloq,
    input  logic                         jogo_ativo,
    output logic [2:0]                   linhas_ativas,
    output logic                         ocupado,
    controle_linhas_bloq_if.master       barramento
);

    localparam logic [LINHA_W-1:0] LINHA_BASE  = LINHA_W'(LINHAS - 1);
    localparam logic [LINHA_W-1:0] LINHA_TOTAL = LINHA_W'(LINHAS);

    estado_t            estado_q;
    logic [2:0]         alvo_q;
    logic [2:0]         ativas_q;
    logic               escreve_q;
    logic [LINHA_W-1:0] endereco_q;
    logic [COLUNAS-1:0] dado_q;

    logic [LINHA_W-1:0] ativas_ext;
    logic [COLUNAS-1:0] linha_cheia;
    logic               conclui;

    assign ativas_ext = LINHA_W'(ativas_q);
    assign conclui    = (estado_q != OCIOSO) && barramento.ack_escrita;

`ifdef LINHAS_BLOQ_BURACO_EN
    localparam int IDX_W = $clog2(COLUNAS);
    logic [IDX_W-1:0] buraco;

    gerador_buraco #(
        .COLUNAS (COLUNAS),
        .IDX_W   (IDX_W)
    ) u_buraco (
        .clock    (clock),
        .reset    (reset),
        .avanca_i (conclui && (estado_q == SOBE)),
        .buraco_o (buraco)
    );

    always_comb begin
        linha_cheia         = '1;
        linha_cheia[buraco] = 1'b0;
    end
`else
    assign linha_cheia = '1;
`endif

    // Outputs are loaded on entry and held until ack, so the writer sees a stable request.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            alvo_q     <= '0;
            ativas_q   <= '0;
            escreve_q  <= 1'b0;
            endereco_q <= '0;
            dado_q     <= '0;
        end else begin
            alvo_q <= linhas_bloq;
            unique case (estado_q)
                OCIOSO: begin
                    if (jogo_ativo && (alvo_q > ativas_q)) begin
                        estado_q   <= SOBE;
                        escreve_q  <= 1'b1;
                        endereco_q <= LINHA_BASE - ativas_ext;
                        dado_q     <= linha_cheia;
                    end else if (jogo_ativo && (alvo_q < ativas_q)) begin
                        estado_q   <= DESCE;
                        escreve_q  <= 1'b1;
                        endereco_q <= LINHA_TOTAL - ativas_ext;
                        dado_q     <= '0;
                    end
                end
                SOBE: begin
                    if (conclui) begin
                        estado_q   <= OCIOSO;
                        escreve_q  <= 1'b0;
                        endereco_q <= '0;
                        dado_q     <= '0;
                        if (ativas_q != MAX_BLOQ) begin
                            ativas_q <= ativas_q + 3'd1;
                        end
                    end
                end
                DESCE: begin
                    if (conclui) begin
                        estado_q   <= OCIOSO;
                        escreve_q  <= 1'b0;
                        endereco_q <= '0;
                        dado_q     <= '0;
                        if (ativas_q != 3'd0) begin
                            ativas_q <= ativas_q - 3'd1;
                        end
                    end
                end
                default: begin
                    estado_q   <= OCIOSO;
                    escreve_q  <= 1'b0;
                    endereco_q <= '0;
                    dado_q     <= '0;
                end
            endcase
        end
    end

    assign barramento.escreve        = escreve_q;
    assign barramento.endereco_linha = endereco_q;
    assign barramento.dado_linha     = dado_q;
    assign ocupado                   = escreve_q;
    assign linhas_ativas             = ativas_q;

endmodule

// File: tb/tb_controle_linhas_bloq.sv
// Scoreboard bench for controle_linhas_bloq: expected row writes are queued by the
// stimulus and popped by a monitor whenever a new write request appears.
module tb_controle_linhas_bloq;

    localparam int COLUNAS = 10;
    localparam int LINHAS  = 20;
    localparam int LINHA_W = 5;

    typedef struct packed {
        logic [LINHA_W-1:0] endr;
        logic [COLUNAS-1:0] dado;
    } transacao_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       jogo;
    logic [2:0] linhas_bloq;
    logic [2:0] ativas;
    logic       ocupado;

    transacao_t esperado[$];
    int         testes   = 0;
    int         falhas   = 0;
    int         buraco_m = 0;

    always #5 clk = ~clk;

    controle_linhas_bloq_if #(.COLUNAS(COLUNAS), .LINHA_W(LINHA_W)) barramento ();

    controle_linhas_bloq #(
        .COLUNAS (COLUNAS),
        .LINHAS  (LINHAS),
        .LINHA_W (LINHA_W)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .linhas_bloq   (linhas_bloq),
        .jogo_ativo    (jogo),
        .linhas_ativas (ativas),
        .ocupado       (ocupado),
        .barramento    (barramento)
    );

    task automatic checar(input string nome, input logic [31:0] obtido, input logic [31:0] exigido);
        testes++;
        if (obtido !== exigido) begin
            falhas++;
            $display("FAIL %s: obtido=%0h exigido=%0h", nome, obtido, exigido);
        end
    endtask

    // Hole model: column advances by 3 mod COLUNAS per inserted row.
    task automatic empilha_sobe(input int linha);
        transacao_t t;
        t.endr = LINHA_W'(linha);
        t.dado = '1;
`ifdef LINHAS_BLOQ_BURACO_EN
        t.dado[buraco_m] = 1'b0;
`endif
        buraco_m = (buraco_m + 3) % COLUNAS;
        esperado.push_back(t);
    endtask

    task automatic empilha_desce(input int linha);
        transacao_t t;
        t.endr = LINHA_W'(linha);
        t.dado = '0;
        esperado.push_back(t);
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic espera_escreve(input string nome, input int limite);
        int k;
        k = 0;
        while (!barramento.escreve && k < limite) begin
            @(negedge clk);
            k++;
        end
        checar(nome, 32'(barramento.escreve), 32'd1);
    endtask

    task automatic checa_zeros(input string pre);
        checar({pre, "_escreve"}, 32'(barramento.escreve), 32'd0);
        checar({pre, "_ocupado"}, 32'(ocupado), 32'd0);
        checar({pre, "_endereco"}, 32'(barramento.endereco_linha), 32'd0);
        checar({pre, "_dado"}, 32'(barramento.dado_linha), 32'd0);
        checar({pre, "_ativas"}, 32'(ativas), 32'd0);
    endtask

    // Monitor: pop on each new request, then hold address/data stable until it drops.
    logic               escreve_ant = 1'b0;
    logic [LINHA_W-1:0] end_ant;
    logic [COLUNAS-1:0] dado_ant;

    always @(negedge clk) begin
        transacao_t t;
        if (barramento.escreve) begin
            if (!escreve_ant) begin
                if (esperado.size() == 0) begin
                    testes++;
                    falhas++;
                    $display("FAIL escrita_inesperada: endereco=%0d dado=%0h exigido=nenhuma",
                             barramento.endereco_linha, barramento.dado_linha);
                end else begin
                    t = esperado.pop_front();
                    checar("endereco", 32'(barramento.endereco_linha), 32'(t.endr));
                    checar("dado", 32'(barramento.dado_linha), 32'(t.dado));
                end
            end else begin
                checar("estavel_endereco", 32'(barramento.endereco_linha), 32'(end_ant));
                checar("estavel_dado", 32'(barramento.dado_linha), 32'(dado_ant));
            end
            checar("ocupado_igual_escreve", 32'(ocupado), 32'd1);
        end
        escreve_ant = barramento.escreve;
        end_ant     = barramento.endereco_linha;
        dado_ant    = barramento.dado_linha;
    end

    initial begin
        #20000;
        $display("FAIL timeout: tempo=%0t limite=20000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic padrao [8];
        padrao = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        reset                  = 1'b1;
        jogo                   = 1'b1;
        linhas_bloq            = 3'd3;
        barramento.ack_escrita = 1'b1;
        ciclos(3);
        checa_zeros("reset");

        // Level 0 -> 3 with ack tied high: rows 19, 18, 17, one idle cycle between.
        empilha_sobe(19);
        empilha_sobe(18);
        empilha_sobe(17);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checar($sformatf("t1_escreve_borda%0d", i + 1), 32'(barramento.escreve), 32'(padrao[i]));
        end
        checar("t1_ativas", 32'(ativas), 32'd3);
        checar("t1_fila", 32'(esperado.size()), 32'd0);

        // Level 3 -> 1: clear rows 17 then 18.
        linhas_bloq = 3'd1;
        empilha_desce(17);
        empilha_desce(18);
        ciclos(8);
        checar("t2_ativas", 32'(ativas), 32'd1);
        checar("t2_fila", 32'(esperado.size()), 32'd0);

        // Delayed ack with a retarget mid-transaction.
        barramento.ack_escrita = 1'b0;
        linhas_bloq            = 3'd4;
        empilha_sobe(18);
        espera_escreve("t3_inicio", 6);
        linhas_bloq = 3'd0;
        empilha_desce(18);
        empilha_desce(19);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checar($sformatf("t3_segura%0d", i), 32'(barramento.escreve), 32'd1);
            checar($sformatf("t3_ativas_segura%0d", i), 32'(ativas), 32'd1);
        end
        barramento.ack_escrita = 1'b1;
        @(negedge clk);
        checar("t3_fim_sobe", 32'(ativas), 32'd2);
        ciclos(8);
        checar("t3_ativas", 32'(ativas), 32'd0);
        checar("t3_fila", 32'(esperado.size()), 32'd0);

        // Game inactive: no request; once active the request follows one edge later.
        jogo        = 1'b0;
        linhas_bloq = 3'd5;
        ciclos(6);
        checar("t4_parado_escreve", 32'(barramento.escreve), 32'd0);
        checar("t4_parado_ativas", 32'(ativas), 32'd0);
        empilha_sobe(19);
        empilha_sobe(18);
        empilha_sobe(17);
        empilha_sobe(16);
        empilha_sobe(15);
        jogo = 1'b1;
        @(negedge clk);
        checar("t4_latencia", 32'(barramento.escreve), 32'd1);
        ciclos(12);
        checar("t4_ativas", 32'(ativas), 32'd5);
        checar("t4_fila", 32'(esperado.size()), 32'd0);

        // Reset while a request is pending.
        barramento.ack_escrita = 1'b0;
        linhas_bloq            = 3'd7;
        empilha_sobe(14);
        espera_escreve("t5_inicio", 6);
        reset = 1'b1;
        @(negedge clk);
        checa_zeros("t5_reset");
        buraco_m               = 0;
        barramento.ack_escrita = 1'b1;
        linhas_bloq            = 3'd5;
        ciclos(2);
        checar("t5_fila", 32'(esperado.size()), 32'd0);

        // Fresh start, 5 rows: hole columns 0, 3, 6, 9, 2 when enabled.
        empilha_sobe(19);
        empilha_sobe(18);
        empilha_sobe(17);
        empilha_sobe(16);
        empilha_sobe(15);
        reset = 1'b0;
        ciclos(14);
        checar("t6_ativas", 32'(ativas), 32'd5);

        // Up to the maximum level, then all the way back to zero.
        linhas_bloq = 3'd7;
        empilha_sobe(14);
        empilha_sobe(13);
        ciclos(8);
        checar("t7_ativas_max", 32'(ativas), 32'd7);
        linhas_bloq = 3'd0;
        for (int l = 13; l <= 19; l++) empilha_desce(l);
        ciclos(18);
        checar("t7_ativas_zero", 32'(ativas), 32'd0);
        checar("t7_escreve", 32'(barramento.escreve), 32'd0);
        checar("t7_fila", 32'(esperado.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/controle_linhas_bloq.md
# controle_linhas_bloq

Synchronous controller that keeps the stack of blocking rows at the bottom of the game board equal to the level requested by the score counter. It sits directly downstream of the score counter and consumes its 3-bit `linhas_bloq` level. It moves the board toward that level one row per write transaction, using a req/ack handshake to the board memory writer.

## Interface
Parameters:
- `COLUNAS`, 10: board width in cells, 4..16.
- `LINHAS`, 20: board height in rows, at least 8.
- `LINHA_W`, 5: row address width, with `2**LINHA_W >= LINHAS`.

Ports:
- `clock`, in, 1: single clock; everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `linhas_bloq`, in, 3: requested blocking-row count, 0..7, from the score counter. It may change at any time and is not assumed synchronous.
- `jogo_ativo`, in, 1: when low, no new transaction starts.
- `escreve`, out, 1: write request to the board writer.
- `endereco_linha`, out, LINHA_W: row address of the request. Row `LINHAS-1` is the bottom row.
- `dado_linha`, out, COLUNAS: row contents, 1 = occupied cell.
- `ack_escrita`, in, 1: board writer acknowledge, sampled while `escreve` is high.
- `linhas_ativas`, out, 3: number of blocking rows currently written.
- `ocupado`, out, 1: high while a transaction is in progress.

## Operation
- `alvo_reg` (3 bits) registers `linhas_bloq` every cycle. It is the only sampling point of the input.
- States:
  - OCIOSO → SOBE when `jogo_ativo` is high and `alvo_reg > linhas_ativas`.
  - OCIOSO → DESCE when `jogo_ativo` is high and `alvo_reg < linhas_ativas`.
  - Otherwise stay in OCIOSO.
  - SOBE / DESCE → OCIOSO on `ack_escrita`.
  - Otherwise hold.
- SOBE:
  - `endereco_linha = LINHAS-1-linhas_ativas`.
  - `dado_linha` is all ones, with a hole as described under Configuration.
  - On ack, `linhas_ativas` increments by 1.
- DESCE:
  - `endereco_linha = LINHAS-linhas_ativas`, the topmost blocking row.
  - `dado_linha` is all zeros.
  - On ack, `linhas_ativas` decrements by 1.
- Each transaction moves exactly one row. A gap of N levels needs N transactions.
- `escreve = ocupado`, and both are high only in SOBE or DESCE.
- `endereco_linha` and `dado_linha` are registered on entry to SOBE/DESCE and stay stable until ack.
- In OCIOSO, `endereco_linha` and `dado_linha` are 0.
- A change of `alvo_reg` during a transaction does not abort it. It is re-evaluated in OCIOSO.
- `jogo_ativo` falling during a transaction: the transaction completes and no further transaction starts.
- `linhas_ativas` saturates:
  - Never exceeds 7.
  - Never wraps below 0. SOBE with 7 and DESCE with 0 are unreachable by construction.
- Reset values, including reset mid-transaction:
  - `escreve`, `ocupado`, `endereco_linha`, `dado_linha`, `linhas_ativas`, `alvo_reg` = 0.
  - State = OCIOSO.
  - Hole index = 0.
- Clearing the board on reset is the board writer's job.

## Timing
- Edge E1: `alvo_reg` captures `linhas_bloq`.
- Edge E2: the FSM leaves OCIOSO, and `escreve` is high after E2.
- Edge E3 with `ack_escrita` high:
  - `linhas_ativas` updates.
  - `escreve` is low after E3.
- Minimum 2 cycles per row. Back-to-back rows: `escreve` goes low for exactly 1 cycle between them.
- `ack_escrita` is ignored in OCIOSO.
- Ack may be held high for several cycles. Each OCIOSO→SOBE/DESCE entry consumes only the ack seen at the end of its own transaction.
- Latency from an input change to the first request is 2 edges.

## Configuration
- Macro: `LINHAS_BLOQ_BURACO_EN`.
- When defined:
  - Each SOBE row has exactly one 0 bit at the hole index `buraco` (0..COLUNAS-1).
  - The index advances by 3 modulo COLUNAS after every acked SOBE, wrapping with a subtraction and no divide.
- When undefined:
  - SOBE rows are all ones.
  - The hole register and its logic are absent.

## Structure
- Package `pacote_linhas_bloq` holds:
  - the state enum `estado_t` (OCIOSO, SOBE, DESCE);
  - `MAX_BLOQ = 7`;
  - `PASSO_BURACO = 3`.
- Sub-module `gerador_buraco` holds the modulo-COLUNAS hole counter with advance-on-strobe. It is instantiated only under `LINHAS_BLOQ_BURACO_EN`.

## Test plan
- Reset with `linhas_bloq` = 3, `jogo_ativo` = 1, ack tied high → three writes to rows 19, 18, 17. The first `escreve` appears 2 edges after reset release, and `linhas_ativas` ends at 3.
- From 3, drop `linhas_bloq` to 1, ack tied high → zero-row writes to rows 17 then 18, and `linhas_ativas` = 1.
- Ack delayed 4 cycles → `escreve`, address and data stay stable for all 4 cycles. Change `linhas_bloq` mid-transaction → the transaction still completes, then the FSM retargets.
- `jogo_ativo` = 0 with `linhas_bloq` = 5 → no `escreve`. Raise `jogo_ativo` → writes begin after 1 edge.
- Assert `reset` while `escreve` is high → after the next edge, every output is 0 and the state is OCIOSO.
- With `LINHAS_BLOQ_BURACO_EN` and COLUNAS = 10, insert 5 rows → holes at columns 0, 3, 6, 9, 2. Without the macro → all rows are 10'h3FF.
